serial_write_controller: RTL
============================

# serial_write_controller

Serial-to-memory write side of the sample memory path. It deserializes a bit stream, sampled on the one-`clk`-wide serial-clock rising-edge strobe, into `dataWidth`-bit words. Each completed word is written into the sample memory at a self-incrementing write address that wraps at `depth-1`. It is the writer counterpart to the program-counter read path and shares the same serial-clock strobe source and memory geometry.

## Interface
- `depth`, 20480: memory depth in words; the write address wraps from `depth-1` to 0.
- `addrWidth`, 15: address width; must satisfy `2**addrWidth >= depth`.
- `dataWidth`, 8: bits per memory word.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sclkPosEdge`  in  1  one-`clk`-wide strobe marking a serial-clock rising edge.
- `wrEn`  in  1  frame enable; bits are accepted only while high.
- `serialIn`  in  1  serial data bit, sampled when `sclkPosEdge && wrEn`.
- `addrClear`  in  1  synchronous request to restart the write address at 0.
- `memWe`  out  1  memory write strobe, one `clk` wide.
- `memAddr`  out  `addrWidth`  memory write address.
- `memData`  out  `dataWidth`  memory write data.
- `wrapped`  out  1  sticky flag: the address has wrapped at least once since reset or `addrClear`.

## Operation
- Reset (async on `rst_n` low) clears everything:
  - `memWe=0`, `memAddr=0`, `memData=0`, `wrapped=0`.
  - Bit counter = 0, shift register = 0, state = IDLE.
- States:
  - IDLE: waiting for `wrEn`.
  - SHIFT: accumulating bits.
  - WRITE: one cycle, `memWe` high.
- Transitions:
  - IDLE -> SHIFT when `wrEn=1`. A strobe in that same cycle is accepted as bit 0.
  - SHIFT, on each `sclkPosEdge && wrEn`: shift `serialIn` in MSB-first (`shift <= {shift[dataWidth-2:0], serialIn}`) and increment the bit counter.
  - SHIFT -> WRITE when bit `dataWidth-1` is accepted. The bit counter returns to 0 and `memData` loads the completed word.
  - WRITE -> SHIFT if `wrEn=1`, otherwise WRITE -> IDLE.
- Address update:
  - `memAddr` is stable for the whole WRITE cycle.
  - On the edge ending WRITE, `memAddr` increments. At `depth-1` it goes to 0 instead, and `wrapped` is set.
- `wrEn` falling in SHIFT with a partial word:
  - Partial bits are discarded and the bit counter is cleared.
  - `memAddr` is unchanged; state goes to IDLE.
  - No write is issued.
- A strobe arriving during WRITE is accepted as bit 0 of the next word, so no bit is lost at word boundaries.
- `addrClear`:
  - Sets `memAddr=0` and `wrapped=0` on the next edge.
  - Discards any partial word.
  - If asserted during WRITE, the write completes at the old address; the post-write increment is suppressed and the address becomes 0.
- Arithmetic: the address compare is against `depth-1` exactly, not against `2**addrWidth-1`. The address never exceeds `depth-1`.

## Timing
- Latency: the final-bit strobe at cycle N gives `memWe=1` at cycle N+1 and the incremented `memAddr` at N+2.
- Maximum throughput is one word per `dataWidth` strobes. Strobes must be at least 2 `clk` apart; the serialClock divider guarantees this for any divisor >= 1.
- `memData` holds its value after WRITE until the next word completes.
- Outputs are registered. There is no combinational path from inputs to outputs.
- Reset mid-word or mid-WRITE aborts immediately; `memWe` drops asynchronously.

## Structure
- Shared package/header:
  - `depth`, `addrWidth` defaults, common with `programCounter` so read and write paths agree.
  - State encodings `ST_IDLE`, `ST_SHIFT`, `ST_WRITE`.
- One natural sub-module, `write_addr_counter`:
  - Wrap-at-`depth-1` counter with clear, increment enable and a `wrapped` output.
  - It mirrors the read-side counter.
- Deserializer and FSM stay in the top module.

## Test plan
- Basic word, `dataWidth=8`, `depth=4`: shift 0xA5 MSB-first with `wrEn=1` -> single `memWe` pulse with `memAddr=0`, `memData=0xA5`; then `memAddr=1`.
- Wrap: write 5 words 0x01..0x05 with `depth=4` -> addresses 0,1,2,3,0.
  - `wrapped` rises on the edge after the 4th write.
  - Final `memAddr=1`.
- Abort: 5 bits, then `wrEn=0`, then full 0x3C -> exactly one write, 0x3C at the unchanged address.
- `addrClear` during WRITE at `memAddr=2` -> write lands at 2; next `memAddr=0`; `wrapped=0`.
- Back-to-back: a strobe arrives in the WRITE cycle -> it becomes bit 0 of the next word.
  - Sending 0xFF then 0x00 gives two writes with correct data.
- Async reset: `rst_n` low mid-shift after 3 bits -> all outputs 0 immediately; the next full word writes at address 0.

Source files
------------

// File: rtl/serial_write_controller_pkg.sv
// ============================================================================
// Module   : serial_write_controller_pkg
// Purpose  : Shared memory geometry and write-FSM state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package serial_write_controller_pkg;

    // Geometry shared with the program-counter read path.
    localparam int c_DEPTH_DEFAULT      = 20480;
    localparam int c_ADDR_WIDTH_DEFAULT = 15;
    localparam int c_DATA_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage : serial_write_controller_pkg

`default_nettype wire

// File: rtl/serial_write_controller_addr_counter.sv
// ============================================================================
// Module   : write_addr_counter
// Purpose  : Write address counter wrapping at DEPTH-1 with sticky wrap flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

import serial_write_controller_pkg::*;

module write_addr_counter #(
    parameter int DEPTH      = c_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_inc,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_wrapped
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_wrapped;

    // Clear wins over increment so a clear during a write suppresses the bump.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr    <= '0;
            r_wrapped <= 1'b0;
        end else if (i_clear) begin
            r_addr    <= '0;
            r_wrapped <= 1'b0;
        end else if (i_inc) begin
            if (r_addr == c_LAST) begin
                r_addr    <= '0;
                r_wrapped <= 1'b1;
            end else begin
                r_addr <= r_addr + 1'b1;
            end
        end
    end

    assign o_addr    = r_addr;
    assign o_wrapped = r_wrapped;

endmodule : write_addr_counter

`default_nettype wire

// File: rtl/serial_write_controller.sv
// ============================================================================
// Module   : serial_write_controller
// Purpose  : Deserializes strobed serial bits into words written to sample memory.
// Revision : 1.0
// ============================================================================
`default_nettype none

import serial_write_controller_pkg::*;

module serial_write_controller #(
    parameter int DEPTH      = c_DEPTH_DEFAULT,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH_DEFAULT,
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclkPosEdge,
    input  logic                  wrEn,
    input  logic                  serialIn,
    input  logic                  addrClear,
    output logic                  memWe,
    output logic [ADDR_WIDTH-1:0] memAddr,
    output logic [DATA_WIDTH-1:0] memData,
    output logic                  wrapped
);

    localparam int                  c_CNT_W    = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST_BIT = c_CNT_W'(DATA_WIDTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_nxt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] w_shift_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] w_data_nxt;
    logic [DATA_WIDTH-1:0] w_shifted;

    assign w_shifted = {r_shift[DATA_WIDTH-2:0], serialIn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_shift <= w_shift_nxt;
            r_data  <= w_data_nxt;
        end
    end

    // The bit counter is zero in IDLE and WRITE, so the same accept path
    // takes bit 0 of a new word in those states without losing a strobe.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_nxt = r_shift;
        w_data_nxt  = r_data;

        case (r_state)
            ST_IDLE:  w_state_nxt = wrEn ? ST_SHIFT : ST_IDLE;
            ST_SHIFT: w_state_nxt = wrEn ? ST_SHIFT : ST_IDLE;
            ST_WRITE: w_state_nxt = wrEn ? ST_SHIFT : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase

        if (!wrEn || addrClear) begin
            w_cnt_nxt   = '0;
            w_shift_nxt = '0;
        end else if (sclkPosEdge) begin
            w_shift_nxt = w_shifted;
            if (r_cnt == c_LAST_BIT) begin
                w_cnt_nxt   = '0;
                w_data_nxt  = w_shifted;
                w_state_nxt = ST_WRITE;
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    write_addr_counter #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (addrClear),
        .i_inc     (r_state == ST_WRITE),
        .o_addr    (memAddr),
        .o_wrapped (wrapped)
    );

    assign memWe   = (r_state == ST_WRITE);
    assign memData = r_data;

endmodule : serial_write_controller

`default_nettype wire
